// File: rtl/ddr3_refresh_sched.sv
// ddr3_refresh_sched
//   Decides when a DDR3 controller should issue REFRESH commands. A free-running
//   tREFI tick counter adds one owed refresh per interval. Owed refreshes are
//   requested only while the controller is idle. Once MAX_POSTPONE refreshes are
//   owed, the scheduler forces an urgent drain that ignores busy_i.
//
// Ports
//   clock      rising-edge clock
//   arst_n     asynchronous active-low reset
//   en_i       scheduler enable (high once DDR3 init is done)
//   busy_i     read/write traffic pending at the controller
//   ref_req_o  registered refresh request to the command FSM
//   ref_ack_i  one-cycle pulse: a REFRESH command was issued
//   urgent_o   registered; high while in forced-drain mode
//   pend_o     refreshes owed, 0..MAX_POSTPONE
//   err_o      sticky: a tick was lost because the owed count was saturated
module ddr3_refresh_sched #(
  parameter int DDR_FREQ_MHZ = 100,
  parameter int TREFI_NS     = 7800,
  parameter int MAX_POSTPONE = 8
) (
  input  logic       clock,
  input  logic       arst_n,
  input  logic       en_i,
  input  logic       busy_i,
  output logic       ref_req_o,
  input  logic       ref_ack_i,
  output logic       urgent_o,
  output logic [3:0] pend_o,
  output logic       err_o
);

  localparam int TREFI_CYC = DDR_FREQ_MHZ * TREFI_NS / 1000;
  localparam int CNT_W     = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TREFI_CYC - 1);
  localparam logic [3:0]       PEND_MAX   = 4'(MAX_POSTPONE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       state_q, state_d;
  logic             ref_req_q, ref_req_d;
  logic             urgent_q, urgent_d;
  logic             err_q, err_d;

  logic tick, ack_acc, can_req_now, can_req_post;

  // tREFI tick counter: parks at the reload value while disabled
  always_comb begin
    tick  = en_i && (cnt_q == '0);
    cnt_d = cnt_q;
    if (!en_i || cnt_q == '0) cnt_d = CNT_RELOAD;
    else                      cnt_d = cnt_q - 1'b1;
  end

  // Owed-refresh counter. A tick and an accepted ack cancel each other, so a
  // saturated count is not flagged as lost when an ack lands on the tick.
  always_comb begin
    ack_acc = ref_ack_i && ref_req_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (!en_i) begin
      pend_d = '0;
      err_d  = 1'b0;
    end else if (tick && !ack_acc) begin
      if (pend_q < PEND_MAX) pend_d = pend_q + 1'b1;
      else                   err_d  = 1'b1;
    end else if (!tick && ack_acc && pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Leaving IDLE uses the registered count (one cycle of latency after the
  // tick); re-arming after an ack and entering DRAIN use the updated count.
  always_comb begin
    can_req_now  = (pend_q != '0) && (pend_q < PEND_MAX) && !busy_i;
    can_req_post = (pend_d != '0) && (pend_d < PEND_MAX) && !busy_i;
    state_d      = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_d == PEND_MAX) state_d = ST_DRAIN;
          else if (can_req_now)   state_d = ST_REQ;
        end
        ST_REQ: begin
          if (pend_d == PEND_MAX) state_d = ST_DRAIN;
          else if (ack_acc)       state_d = can_req_post ? ST_REQ : ST_IDLE;
        end
        ST_DRAIN: begin
          if (ack_acc && pend_d == '0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ref_req_d = (state_d != ST_IDLE);
    urgent_d  = (state_d == ST_DRAIN);
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q     <= CNT_RELOAD;
      pend_q    <= '0;
      state_q   <= ST_IDLE;
      ref_req_q <= 1'b0;
      urgent_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      ref_req_q <= ref_req_d;
      urgent_q  <= urgent_d;
      err_q     <= err_d;
    end
  end

  assign ref_req_o = ref_req_q;
  assign urgent_o  = urgent_q;
  assign pend_o    = pend_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ddr3_refresh_sched.sv
// Bench for ddr3_refresh_sched with TREFI_CYC=10, MAX_POSTPONE=4. A cycle-level
// model tracks the enabled-cycle phase, the owed count and the request/urgent
// flags by the scheduling rules; directed scenarios also check fixed values.
module tb_ddr3_refresh_sched;

  localparam int TREFI_CYC = 10;
  localparam int MAXP      = 4;

  logic       clock = 1'b0;
  logic       arst_n, en, busy, ack;
  logic       ref_req_o, urgent_o, err_o;
  logic [3:0] pend_o;

  int total = 0;
  int bad   = 0;

  // model state
  int m_phase, m_pend;
  bit m_req, m_urg, m_err;

  ddr3_refresh_sched #(
    .DDR_FREQ_MHZ(100), .TREFI_NS(100), .MAX_POSTPONE(MAXP)
  ) dut (
    .clock(clock), .arst_n(arst_n), .en_i(en), .busy_i(busy),
    .ref_req_o(ref_req_o), .ref_ack_i(ack), .urgent_o(urgent_o),
    .pend_o(pend_o), .err_o(err_o)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_phase = 0; m_pend = 0; m_req = 0; m_urg = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit tick, acc;
    int np;
    if (!en) begin
      model_reset();
      return;
    end
    tick    = (m_phase == TREFI_CYC - 1);
    m_phase = (m_phase + 1) % TREFI_CYC;
    acc     = ack && m_req;
    np      = m_pend + (tick ? 1 : 0) - (acc ? 1 : 0);
    if (np > MAXP) begin np = MAXP; m_err = 1; end
    if (np < 0) np = 0;
    if (m_urg) begin
      if (acc && np == 0) begin m_req = 0; m_urg = 0; end
    end else if (np == MAXP) begin
      m_req = 1; m_urg = 1;
    end else if (m_req && !acc) begin
      m_req = 1;
    end else if (m_req) begin
      m_req = (np > 0 && np < MAXP && !busy);
    end else begin
      m_req = (m_pend > 0 && m_pend < MAXP && !busy);
    end
    m_pend = np;
  endtask

  // advance one clock, update the model, land 1 ns after the edge
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; en = 1'b1; busy = 1'b0; ack = 1'b0;
    #12;
    model_reset();
    total++;
    if ({ref_req_o, urgent_o, pend_o, err_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset got req=%b urg=%b pend=%0d err=%b want all 0",
               ref_req_o, urgent_o, pend_o, err_o);
    end
    en = 1'b0;
    arst_n = 1'b1;
    step();
  endtask

  // first request 11 cycles after enable, acked 2 cycles after each rise
  task automatic test_basic();
    int hi_cnt, rises;
    bit prev;
    en = 1'b1; busy = 1'b0; ack = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 10) begin
        total++;
        if (ref_req_o !== 1'b0 || pend_o !== 4'd1) begin
          bad++;
          $display("FAIL basic_c10 got req=%b pend=%0d want req=0 pend=1", ref_req_o, pend_o);
        end
      end
    end
    total++;
    if (ref_req_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_first_req got %b want 1 at cycle 11", ref_req_o);
    end
    hi_cnt = 1; rises = 0; prev = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ack = (hi_cnt == 2);
      step();
      if (ref_req_o && !prev) rises++;
      prev   = ref_req_o;
      hi_cnt = ref_req_o ? hi_cnt + 1 : 0;
      total++;
      if (ref_req_o !== m_req || urgent_o !== m_urg || pend_o !== 4'(m_pend) || err_o !== m_err) begin
        bad++;
        $display("FAIL basic_model i=%0d got req=%b urg=%b pend=%0d err=%b want req=%b urg=%b pend=%0d err=%b",
                 i, ref_req_o, urgent_o, pend_o, err_o, m_req, m_urg, m_pend, m_err);
      end
    end
    ack = 1'b0;
    total++;
    if (rises !== 3) begin
      bad++;
      $display("FAIL basic_rate got %0d rises want 3", rises);
    end
  endtask

  // busy blocks requests until saturation forces a drain; lost tick sets err
  task automatic test_saturate();
    en = 1'b0; busy = 1'b1; ack = 1'b0;
    step();
    en = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 39) begin
        total++;
        if (pend_o !== 4'd3 || ref_req_o !== 1'b0) begin
          bad++;
          $display("FAIL sat_c39 got pend=%0d req=%b want pend=3 req=0", pend_o, ref_req_o);
        end
      end
      if (i == 40) begin
        total++;
        if (pend_o !== 4'd4 || ref_req_o !== 1'b1 || urgent_o !== 1'b1 || err_o !== 1'b0) begin
          bad++;
          $display("FAIL sat_c40 got pend=%0d req=%b urg=%b err=%b want 4 1 1 0",
                   pend_o, ref_req_o, urgent_o, err_o);
        end
      end
    end
    total++;
    if (err_o !== 1'b1 || pend_o !== 4'd4) begin
      bad++;
      $display("FAIL sat_err got err=%b pend=%0d want err=1 pend=4", err_o, pend_o);
    end
    ack = 1'b1;
    for (int i = 0; i < 10 && m_req; i++) begin
      step();
      total++;
      if (ref_req_o !== m_req || urgent_o !== m_urg || pend_o !== 4'(m_pend)) begin
        bad++;
        $display("FAIL sat_drain i=%0d got req=%b urg=%b pend=%0d want %b %b %0d",
                 i, ref_req_o, urgent_o, pend_o, m_req, m_urg, m_pend);
      end
    end
    ack = 1'b0;
    total++;
    if (ref_req_o !== 1'b0 || urgent_o !== 1'b0 || pend_o !== 4'd0 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL sat_done got req=%b urg=%b pend=%0d err=%b want 0 0 0 1",
               ref_req_o, urgent_o, pend_o, err_o);
    end
    en = 1'b0;
    step();
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL sat_err_clear got %b want 0", err_o);
    end
  endtask

  // tick and ack together at the ceiling: no change, no error
  task automatic test_tick_ack_at_max();
    en = 1'b1; busy = 1'b1; ack = 1'b0;
    for (int i = 0; i < 49; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (pend_o !== 4'd4 || err_o !== 1'b0 || urgent_o !== 1'b1) begin
      bad++;
      $display("FAIL tick_ack_max got pend=%0d err=%b urg=%b want 4 0 1", pend_o, err_o, urgent_o);
    end
    en = 1'b0;
    step();
  endtask

  // request held across busy; ack while not requesting is ignored
  task automatic test_busy_hold();
    en = 1'b1; busy = 1'b0; ack = 1'b0;
    for (int i = 0; i < 11; i++) step();
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (ref_req_o !== 1'b1) begin
        bad++;
        $display("FAIL busy_hold i=%0d got req=%b want 1", i, ref_req_o);
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (ref_req_o !== 1'b0 || pend_o !== 4'd0) begin
      bad++;
      $display("FAIL busy_ack got req=%b pend=%0d want 0 0", ref_req_o, pend_o);
    end
    for (int i = 0; i < 12 && m_pend != 1; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (pend_o !== 4'd1 || ref_req_o !== 1'b0) begin
      bad++;
      $display("FAIL stray_ack got pend=%0d req=%b want pend=1 req=0", pend_o, ref_req_o);
    end
    en = 1'b0;
    step();
  endtask

  task automatic reach_drain3();
    en = 1'b1; busy = 1'b1; ack = 1'b0;
    for (int i = 0; i < 40; i++) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (pend_o !== 4'd3 || urgent_o !== 1'b1 || ref_req_o !== 1'b1) begin
      bad++;
      $display("FAIL drain3 got pend=%0d urg=%b req=%b want 3 1 1", pend_o, urgent_o, ref_req_o);
    end
  endtask

  task automatic test_abort();
    reach_drain3();
    en = 1'b0;
    step();
    total++;
    if ({ref_req_o, urgent_o, pend_o, err_o} !== 7'b0) begin
      bad++;
      $display("FAIL en_abort got req=%b urg=%b pend=%0d err=%b want all 0",
               ref_req_o, urgent_o, pend_o, err_o);
    end
    reach_drain3();
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({ref_req_o, urgent_o, pend_o, err_o} !== 7'b0) begin
      bad++;
      $display("FAIL arst_abort got req=%b urg=%b pend=%0d err=%b want all 0",
               ref_req_o, urgent_o, pend_o, err_o);
    end
    en = 1'b0;
    #1 arst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 199) != 0);
      busy = ($urandom_range(0, 99) < ((i / 500) % 2 ? 85 : 40));
      ack  = ($urandom_range(0, 99) < 30);
      step();
      total++;
      if (ref_req_o !== m_req || urgent_o !== m_urg || pend_o !== 4'(m_pend) || err_o !== m_err) begin
        bad++;
        $display("FAIL random i=%0d got req=%b urg=%b pend=%0d err=%b want req=%b urg=%b pend=%0d err=%b",
                 i, ref_req_o, urgent_o, pend_o, err_o, m_req, m_urg, m_pend, m_err);
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_tick_ack_at_max();
    test_busy_hold();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
